// File: rtl/i2s_dma_sequencer.sv
// i2s_dma_sequencer: Wishbone read sequencer refilling the I2S controller from a circular buffer.
// Optional buffer-progress interrupt is built only when I2S_DMA_IRQ_EN is defined.
module i2s_dma_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [SIZE_WIDTH-1:0] buffer_size,
  input  logic                  request_data,
  input  logic [SIZE_WIDTH-1:0] request_size,
  output logic                  request_finished,
  output logic [31:0]           memory_data,
  output logic                  memory_data_strobe,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [3:0]            m_sel,
  output logic [ADDR_WIDTH-1:0] m_adr,
  input  logic [31:0]           m_dat_i,
  input  logic                  m_ack,
  output logic                  busy,
  output logic [SIZE_WIDTH-1:0] read_pointer,
  output logic                  irq
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_ACK, GAP, FINISH} state_t;
  state_t r_state, w_next;
  logic [SIZE_WIDTH-1:0] r_count;
  logic [SIZE_WIDTH:0]   w_inc;
  logic [SIZE_WIDTH-1:0] w_ptr_next;
  logic                  w_beat;
  logic                  w_last;
  assign w_beat     = (r_state == WAIT_ACK) && m_ack;
  assign w_last     = (r_count == SIZE_WIDTH'(1)) || !enable;
  assign w_inc      = {1'b0, read_pointer} + {{SIZE_WIDTH{1'b0}}, 1'b1};
  // >= rather than == so a buffer shrunk below the pointer still wraps
  assign w_ptr_next = (w_inc >= {1'b0, buffer_size}) ? '0 : w_inc[SIZE_WIDTH-1:0];
  assign busy       = r_state != IDLE;
  assign m_we       = 1'b0;
  assign m_sel      = m_stb ? 4'hF : 4'h0;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (request_data && enable) ? SETUP : IDLE;
      SETUP:    w_next = (r_count == '0 || buffer_size == '0) ? FINISH : STROBE;
      STROBE:   w_next = WAIT_ACK;
      WAIT_ACK: w_next = m_ack ? (w_last ? FINISH : GAP) : WAIT_ACK;
      GAP:      w_next = STROBE;
      FINISH:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count            <= '0;
      read_pointer       <= '0;
      memory_data        <= '0;
      memory_data_strobe <= 1'b0;
      request_finished   <= 1'b0;
      m_cyc              <= 1'b0;
      m_stb              <= 1'b0;
      m_adr              <= '0;
    end else begin
      memory_data_strobe <= w_beat;
      request_finished   <= r_state == FINISH;
      if (r_state == IDLE && request_data && enable) r_count <= request_size;
      if (r_state == IDLE && !enable) read_pointer <= '0;
      if (r_state == SETUP && w_next == STROBE) begin
        m_cyc <= 1'b1;
        m_stb <= 1'b1;
        m_adr <= base_address + ADDR_WIDTH'(read_pointer);
      end
      if (r_state == GAP) m_stb <= 1'b1;
      if (w_beat) begin
        memory_data  <= m_dat_i;
        r_count      <= r_count - SIZE_WIDTH'(1);
        read_pointer <= w_ptr_next;
        m_stb        <= 1'b0;
        m_adr        <= w_last ? m_adr : base_address + ADDR_WIDTH'(w_ptr_next);
      end
      if (r_state == FINISH) m_cyc <= 1'b0;
    end
  end
`ifdef I2S_DMA_IRQ_EN
  // half-point and wrap can coincide only for size 1, giving one pulse
  always_ff @(posedge clk)
    irq <= rst ? 1'b0 : w_beat && (w_ptr_next == (buffer_size >> 1) || w_ptr_next == '0);
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_dma_sequencer.sv
// tb_i2s_dma_sequencer: directed checks of the refill sequencer against a simple Wishbone slave.
module tb_i2s_dma_sequencer;
  logic        clk = 0, rst = 1, enable = 0, request_data = 0, m_ack = 0;
  logic [31:0] base_address = 32'h1000, m_dat_i = 0, m_adr, memory_data;
  logic [23:0] buffer_size = 24'd8, request_size = 0, read_pointer;
  logic        request_finished, memory_data_strobe, m_cyc, m_stb, m_we, busy, irq;
  logic [3:0]  m_sel;
  int n_tests = 0, n_fail = 0, cyc = 0, req_cyc = 0;
  int first_stb, fin_cyc, last_strb, n_fin, n_irq, overlap, unstable, bus_err, cyc_seen;
  int wait_cnt = 0, b_idx = 0, stall_at = -1;
  logic        prev_stb = 0;
  logic [31:0] prev_adr = 0;
  logic [31:0] adr_q[$], dat_q[$];
`ifdef I2S_DMA_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  always #5 clk = ~clk;

  i2s_dma_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .base_address(base_address),
    .buffer_size(buffer_size), .request_data(request_data), .request_size(request_size),
    .request_finished(request_finished), .memory_data(memory_data),
    .memory_data_strobe(memory_data_strobe), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_sel(m_sel), .m_adr(m_adr), .m_dat_i(m_dat_i), .m_ack(m_ack), .busy(busy),
    .read_pointer(read_pointer), .irq(irq)
  );

  function automatic logic [31:0] pat(logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // slave then monitor, both at the falling edge
  always @(negedge clk) begin
    if (m_stb && !m_ack) begin
      if (wait_cnt >= ((b_idx == stall_at) ? 11 : 1)) begin
        m_ack = 1;
        m_dat_i = pat(m_adr);
        b_idx++;
      end else wait_cnt++;
    end else begin
      m_ack = 0;
      wait_cnt = 0;
    end
    if (m_cyc) cyc_seen++;
    if (m_stb && m_ack) adr_q.push_back(m_adr);
    if (memory_data_strobe) begin dat_q.push_back(memory_data); last_strb = cyc; end
    if (request_finished) begin n_fin++; fin_cyc = cyc; end
    if (irq) n_irq++;
    if (memory_data_strobe && request_finished) overlap++;
    if (m_stb && prev_stb && m_adr !== prev_adr) unstable++;
    if (m_we !== 1'b0 || m_sel !== (m_stb ? 4'hF : 4'h0)) bus_err++;
    if (m_stb && first_stb < 0) first_stb = cyc;
    prev_stb = m_stb;
    prev_adr = m_adr;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    adr_q.delete(); dat_q.delete();
    first_stb = -1; n_fin = 0; n_irq = 0; overlap = 0; unstable = 0;
    bus_err = 0; cyc_seen = 0; b_idx = 0;
  endtask

  task automatic req(int sz);
    request_size = 24'(sz);
    request_data = 1;
    req_cyc = cyc;
    step();
    request_data = 0;
  endtask

  task automatic wait_fin(int maxc);
    for (int i = 0; i < maxc && n_fin == 0; i++) step();
    chk("finish_seen", 32'(n_fin != 0), 1);
  endtask

  task automatic chk_beats(string tag, int n, logic [31:0] a0);
    chk({tag, "_nadr"}, 32'(adr_q.size()), 32'(n));
    chk({tag, "_ndat"}, 32'(dat_q.size()), 32'(n));
    for (int i = 0; i < n && i < adr_q.size() && i < dat_q.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), adr_q[i], a0 + ((32'(i) + a0[2:0]) % 8) - a0[2:0]);
      chk($sformatf("%s_dat%0d", tag, i), dat_q[i], pat(a0 + ((32'(i) + a0[2:0]) % 8) - a0[2:0]));
    end
    chk({tag, "_overlap"}, 32'(overlap), 0);
    chk({tag, "_buserr"}, 32'(bus_err), 0);
  endtask

  initial begin
    clear_log();
    step(); step();
    chk("rst_cyc", 32'(m_cyc), 0);
    chk("rst_stb", 32'(m_stb), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rp", 32'(read_pointer), 0);
    chk("rst_fin", 32'(request_finished), 0);
    chk("rst_mds", 32'(memory_data_strobe), 0);
    chk("rst_md", memory_data, 0);
    chk("rst_adr", m_adr, 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 0;
    enable = 1;
    step();
    // 4 words from offset 0
    clear_log();
    req(4);
    wait_fin(100);
    chk_beats("t1", 4, 32'h1000);
    chk("t1_lat_stb", 32'(first_stb - req_cyc), 2);
    chk("t1_fin_after_strobe", 32'(fin_cyc - last_strb), 1);
    chk("t1_rp", 32'(read_pointer), 4);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_irq", 32'(n_irq), 32'(IRQ_ON));
    step();
    // 6 words crossing the wrap; a request mid-burst must be ignored
    clear_log();
    req(6);
    step(); step(); step();
    req(1);
    wait_fin(100);
    for (int i = 0; i < 5; i++) step();
    chk_beats("t2", 6, 32'h1004);
    chk("t2_rp", 32'(read_pointer), 2);
    chk("t2_nfin", 32'(n_fin), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_irq", 32'(n_irq), 32'(IRQ_ON));
    // zero-length request
    clear_log();
    req(0);
    wait_fin(20);
    chk("t3_lat_fin", 32'(fin_cyc - req_cyc), 3);
    chk("t3_nocyc", 32'(cyc_seen), 0);
    chk("t3_rp", 32'(read_pointer), 2);
    step();
    // zero-size buffer
    buffer_size = 0;
    clear_log();
    req(3);
    wait_fin(20);
    chk("t4_lat_fin", 32'(fin_cyc - req_cyc), 3);
    chk("t4_nocyc", 32'(cyc_seen), 0);
    chk("t4_nstrobe", 32'(dat_q.size()), 0);
    step();
    buffer_size = 8;
    // 10-cycle ack stall on beat 2 of 3
    clear_log();
    stall_at = 1;
    req(3);
    wait_fin(100);
    chk_beats("t5", 3, 32'h1002);
    chk("t5_unstable", 32'(unstable), 0);
    chk("t5_lat_fin", 32'(fin_cyc - req_cyc), 21);
    chk("t5_rp", 32'(read_pointer), 5);
    chk("t5_irq", 32'(n_irq), 32'(IRQ_ON));
    step();
    // enable falls while beat 2 of 5 waits for ack
    clear_log();
    stall_at = 1;
    req(5);
    for (int i = 0; i < 50 && !(adr_q.size() == 1 && m_stb); i++) step();
    chk("t6_reached_beat2", 32'(adr_q.size() == 1 && m_stb), 1);
    step(); step(); step();
    enable = 0;
    wait_fin(100);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rp_at_fin", 32'(read_pointer), 7);
    chk_beats("t6", 2, 32'h1005);
    chk("t6_irq", 32'(n_irq), 0);
    step();
    chk("t6_rp_cleared", 32'(read_pointer), 0);
    // request while disabled is ignored
    clear_log();
    req(2);
    for (int i = 0; i < 5; i++) step();
    chk("t7_busy", 32'(busy), 0);
    chk("t7_nocyc", 32'(cyc_seen), 0);
    chk("t7_nfin", 32'(n_fin), 0);
    // reset while waiting for ack
    enable = 1;
    step();
    clear_log();
    stall_at = 0;
    req(4);
    for (int i = 0; i < 20 && !m_stb; i++) step();
    step(); step();
    chk("t8_in_wait", 32'(m_stb && busy), 1);
    chk("t8_rp_pre", 32'(read_pointer), 0);
    rst = 1;
    step();
    chk("t8_cyc", 32'(m_cyc), 0);
    chk("t8_stb", 32'(m_stb), 0);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_rp", 32'(read_pointer), 0);
    rst = 0;
    stall_at = -1;
    for (int i = 0; i < 5; i++) step();
    chk("t8_nfin", 32'(n_fin), 0);
    chk("t8_nstrobe", 32'(dat_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
